// File: rtl/ball_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ball_pkg                                                     |
// | Description : Shared types and constants for the Breakout ball controller: |
// |               FSM state encoding, block-hit codes and direction encodings. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2
    } ball_state_e;

    // OR-ed block hit codes: bit 0 reverses the vertical direction,
    // bit 1 the horizontal one, both together mean a corner hit.
    localparam logic [1:0] HIT_NONE = 2'b00;
    localparam logic [1:0] HIT_V    = 2'b01;
    localparam logic [1:0] HIT_H    = 2'b10;
    localparam logic [1:0] HIT_C    = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Width of the move-tick divider value and counter.
    localparam int unsigned c_div_w = 8;

endpackage
`default_nettype wire

// File: rtl/ball_tick_div.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ball_tick_div                                                |
// | Description : Divides the qualified animation strobe down to move ticks.   |
// |               The counter advances on every stb&en and wraps at div-1,     |
// |               firing tick in the wrap cycle.                               |
// | Ports       : clk, rst (sync, active-high), clr (sync clear), stb, en,     |
// |               div [c_div_w] (>=1), tick (combinational)                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ball_tick_div
    import ball_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               stb,
    input  logic               en,
    input  logic [c_div_w-1:0] div,
    output logic               tick
);

    localparam logic [c_div_w-1:0] c_one = c_div_w'(1);

    logic [c_div_w-1:0] r_cnt;
    logic               w_wrap;

    // >= rather than == so a divider that shrinks while the count is
    // already past the new limit still wraps instead of running to 255.
    assign w_wrap = (r_cnt >= (div - c_one));
    assign tick   = stb && en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (stb && en) begin
            r_cnt <= w_wrap ? '0 : (r_cnt + c_one);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ball_ctrl                                                    |
// | Description : Breakout ball owner. Steps the ball centre 1 px per axis on  |
// |               each move tick, bounces off walls, paddle and blocks, acks   |
// |               consumed block hits and tracks IDLE/PLAY/LOST.               |
// | Ports       : i_clk, i_rst (sync, active-high), i_ani_stb, i_animate,      |
// |               start, i_hit_block[2], i_px1/i_px2/i_py1[12] paddle,         |
// |               o_x/o_y[12] centre, o_x1/o_x2/o_y1/o_y2[12] edges,           |
// |               col_detected, o_lost, o_state[2]                             |
// | Config      : BALL_SPEEDUP_EN - every HITS_LVL block hits shorten the move |
// |               divider by one (floor 1); undefined keeps SLOW_DIV fixed.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned H_SIZE   = 10,
    parameter int unsigned IX       = 320,
    parameter int unsigned IY       = 400,
    parameter int unsigned D_WIDTH  = 640,
    parameter int unsigned D_HEIGHT = 480,
    parameter int unsigned SLOW_DIV = 2,
    parameter int unsigned HITS_LVL = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        start,
    input  logic [1:0]  i_hit_block,
    input  logic [11:0] i_px1,
    input  logic [11:0] i_px2,
    input  logic [11:0] i_py1,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic        col_detected,
    output logic        o_lost,
    output logic [1:0]  o_state
);

    localparam logic [11:0]        c_h        = 12'(H_SIZE);
    localparam logic [11:0]        c_x_min    = 12'(H_SIZE);
    localparam logic [11:0]        c_x_max    = 12'(D_WIDTH - 1 - H_SIZE);
    localparam logic [11:0]        c_y_min    = 12'(H_SIZE);
    localparam logic [11:0]        c_y_bot    = 12'(D_HEIGHT - 1);
    localparam logic [11:0]        c_ix       = 12'(IX);
    localparam logic [11:0]        c_iy       = 12'(IY);
    localparam logic [c_div_w-1:0] c_slow_div = c_div_w'(SLOW_DIV);

    ball_state_e        r_state;
    ball_state_e        w_state_nxt;
    logic [11:0]        r_x;
    logic [11:0]        r_y;
    logic               r_dx;
    logic               r_dy;
    logic               r_col;
    logic [1:0]         r_guard;

    logic               w_play;
    logic               w_hit_ok;
    logic               w_wall_x;
    logic               w_wall_y;
    logic               w_paddle;
    logic               w_bottom;
    logic               w_flip_x;
    logic               w_flip_y;
    logic               w_mv_dx;
    logic               w_mv_dy;
    logic               w_tick;
    logic               w_move;
    logic [c_div_w-1:0] w_div;

    assign w_play   = (r_state == PLAY);

    // The guard hides the stale code the blocks keep driving until they
    // have seen col_detected and cleared themselves.
    assign w_hit_ok = w_play && (i_hit_block != HIT_NONE) && (r_guard == 2'd0);

    assign w_wall_x = ((r_x == c_x_min) && (r_dx == DIR_LEFT)) ||
                      ((r_x == c_x_max) && (r_dx == DIR_RIGHT));
    assign w_wall_y = (r_y == c_y_min) && (r_dy == DIR_UP);
    assign w_paddle = (r_dy == DIR_DOWN) && ((r_y + c_h) == i_py1) &&
                      (r_x >= i_px1) && (r_x <= i_px2);
    assign w_bottom = ((r_y + c_h) >= c_y_bot);

    // Per-axis reversals are OR-ed so a wall and a block on the same axis
    // in the same cycle reverse the ball only once.
    assign w_flip_x = w_play && (w_wall_x || (w_hit_ok && i_hit_block[1]));
    assign w_flip_y = w_play && (w_wall_y || w_paddle || (w_hit_ok && i_hit_block[0]));

    // Wall and paddle bounces steer the move of the same cycle so the ball
    // never steps outside the field; block hits only take effect on the
    // following move.
    assign w_mv_dx  = r_dx ^ w_wall_x;
    assign w_mv_dy  = r_dy ^ (w_wall_y || w_paddle);
    assign w_move   = w_tick && !w_bottom;

`ifdef BALL_SPEEDUP_EN
    logic [7:0] r_hits;
    logic [7:0] w_lvl;

    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == IDLE)) begin
            r_hits <= '0;
        end else if (w_hit_ok && (r_hits != 8'hFF)) begin
            r_hits <= r_hits + 8'd1;
        end
    end

    assign w_lvl = r_hits / 8'(HITS_LVL);
    assign w_div = ((32'(w_lvl) + 32'd1) >= 32'(SLOW_DIV)) ? c_div_w'(1)
                                                            : (c_slow_div - w_lvl);
`else
    assign w_div = c_slow_div;
`endif

    ball_tick_div u_tick_div (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (r_state == IDLE),
        .stb  (i_ani_stb),
        .en   (i_animate && w_play),
        .div  (w_div),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)    w_state_nxt = PLAY;
            PLAY:    if (w_bottom) w_state_nxt = LOST;
            LOST:    if (!start)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_x     <= c_ix;
            r_y     <= c_iy;
            r_dx    <= DIR_RIGHT;
            r_dy    <= DIR_UP;
            r_col   <= 1'b0;
            r_guard <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_hit_ok;
            if (w_hit_ok) begin
                r_guard <= 2'd2;
            end else if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end
            // Parking on entry to IDLE shows the serve position as soon
            // as the FSM reports IDLE.
            if (w_state_nxt == IDLE) begin
                r_x  <= c_ix;
                r_y  <= c_iy;
                r_dx <= DIR_RIGHT;
                r_dy <= DIR_UP;
            end else begin
                if (w_move) begin
                    r_x <= (w_mv_dx == DIR_RIGHT) ? (r_x + 12'd1) : (r_x - 12'd1);
                    r_y <= (w_mv_dy == DIR_DOWN)  ? (r_y + 12'd1) : (r_y - 12'd1);
                end
                if (w_flip_x) r_dx <= ~r_dx;
                if (w_flip_y) r_dy <= ~r_dy;
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_x1         = r_x - c_h;
    assign o_x2         = r_x + c_h;
    assign o_y1         = r_y - c_h;
    assign o_y2         = r_y + c_h;
    assign col_detected = r_col;
    assign o_lost       = (r_state == LOST);
    assign o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ball_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ball_ctrl                                                 |
// | Description : Self-checking bench for ball_ctrl: serve, block hits with    |
// |               guard, wall/paddle bounces, LOST/IDLE, reset mid-play and    |
// |               the optional BALL_SPEEDUP_EN divider.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ball_ctrl;
    import ball_pkg::*;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        ani_stb   = 1'b0;
    logic        animate   = 1'b1;
    logic        start     = 1'b0;
    logic [1:0]  hit_block = HIT_NONE;
    logic [11:0] px1       = 12'd48;
    logic [11:0] px2       = 12'd127;
    logic [11:0] py1       = 12'd440;
    logic [11:0] x, y, x1, x2, y1, y2;
    logic        col_detected;
    logic        lost;
    logic [1:0]  state;

    ball_ctrl #(
        .H_SIZE(10), .IX(320), .IY(400), .D_WIDTH(640), .D_HEIGHT(480),
        .SLOW_DIV(2), .HITS_LVL(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_animate(animate),
        .start(start), .i_hit_block(hit_block),
        .i_px1(px1), .i_px2(px2), .i_py1(py1),
        .o_x(x), .o_y(y), .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
        .col_detected(col_detected), .o_lost(lost), .o_state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_ack;

    typedef struct {
        logic       anim;
        logic       stb;
        logic [1:0] hit;
        int         ex;
        int         ey;
        logic       ecol;
    } vec_t;

    vec_t tbl [18];
    vec_t sbq [$];
    vec_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pos(input string name, input int ex, input int ey);
        check({name, " x"}, 32'(x), ex);
        check({name, " y"}, 32'(y), ey);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One animation strobe: an idle cycle, then a strobe cycle.
    task automatic strobe();
        ani_stb = 1'b0;
        cyc();
        ani_stb = 1'b1;
        cyc();
        ani_stb = 1'b0;
    endtask

    // n ball moves at the default divider of 2.
    task automatic fly(input int n);
        repeat (2 * n) strobe();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Block-hit table, one record per cycle, starting in the first PLAY
        // cycle at (320,400) heading right/up with the divider at 0.
        tbl[0]  = '{1'b1, 1'b0, HIT_V,    320, 400, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, HIT_NONE, 320, 400, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, HIT_NONE, 320, 400, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, HIT_NONE, 320, 400, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, HIT_NONE, 321, 401, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, HIT_H,    321, 401, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, HIT_H,    321, 401, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, HIT_NONE, 321, 401, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, HIT_NONE, 321, 401, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, HIT_NONE, 320, 402, 1'b0};
        tbl[10] = '{1'b1, 1'b1, HIT_NONE, 320, 402, 1'b0};
        tbl[11] = '{1'b1, 1'b1, HIT_C,    319, 403, 1'b1};
        tbl[12] = '{1'b1, 1'b0, HIT_NONE, 319, 403, 1'b0};
        tbl[13] = '{1'b1, 1'b1, HIT_NONE, 319, 403, 1'b0};
        tbl[14] = '{1'b1, 1'b1, HIT_NONE, 320, 402, 1'b0};
        tbl[15] = '{1'b0, 1'b1, HIT_NONE, 320, 402, 1'b0};
        tbl[16] = '{1'b1, 1'b1, HIT_NONE, 320, 402, 1'b0};
        tbl[17] = '{1'b1, 1'b1, HIT_NONE, 321, 401, 1'b0};

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        check("reset state", 32'(state), 32'(IDLE));
        check_pos("reset", 320, 400);
        check("reset x1", 32'(x1), 310);
        check("reset x2", 32'(x2), 330);
        check("reset y1", 32'(y1), 390);
        check("reset y2", 32'(y2), 410);
        check("reset col", 32'(col_detected), 0);
        check("reset lost", 32'(lost), 0);
        rst = 1'b0;

        // Hits outside PLAY are ignored
        hit_block = HIT_C;
        cyc();
        check("idle hit col", 32'(col_detected), 0);
        check("idle hit state", 32'(state), 32'(IDLE));
        hit_block = HIT_NONE;

        // Game 1: serve, wall bounce with coincident block hit, top wall,
        // paddle miss by one pixel, LOST, back to IDLE.
        start = 1'b1;
        cyc();
        check("serve state", 32'(state), 32'(PLAY));
        strobe();
        check_pos("serve 1 strobe", 320, 400);
        strobe();
        check_pos("serve 2 strobes", 321, 399);
        fly(308);
        check_pos("g1 right wall", 629, 91);
        check("g1 right wall x2", 32'(x2), 639);
        check("g1 right wall y1", 32'(y1), 81);
        hit_block = HIT_H;
        cyc();
        hit_block = HIT_NONE;
        check("g1 wall+hit col", 32'(col_detected), 1);
        cyc();
        check("g1 wall+hit col end", 32'(col_detected), 0);
        fly(1);
        check_pos("g1 after wall+hit", 628, 90);
        fly(1);
        check_pos("g1 keeps left", 627, 89);
        fly(499);
        check_pos("g1 paddle row", 128, 430);
        fly(1);
        check_pos("g1 paddle miss", 127, 431);
        fly(38);
        check_pos("g1 bottom", 89, 469);
        cyc();
        check("g1 lost state", 32'(state), 32'(LOST));
        check("g1 lost flag", 32'(lost), 1);
        strobe();
        strobe();
        check_pos("g1 frozen", 89, 469);
        hit_block = HIT_V;
        cyc();
        hit_block = HIT_NONE;
        check("g1 lost hit col", 32'(col_detected), 0);
        check("g1 lost held", 32'(state), 32'(LOST));
        start = 1'b0;
        cyc();
        check("g1 idle state", 32'(state), 32'(IDLE));
        check("g1 idle lost", 32'(lost), 0);
        check_pos("g1 parked", 320, 400);

        // Game 2: same flight, plain wall bounces, paddle hit on its right edge.
        px2 = 12'd128;
        start = 1'b1;
        cyc();
        check("g2 state", 32'(state), 32'(PLAY));
        fly(309);
        check_pos("g2 right wall", 629, 91);
        fly(1);
        check_pos("g2 wall bounce", 628, 90);
        fly(80);
        check_pos("g2 top wall", 548, 10);
        fly(1);
        check_pos("g2 top bounce", 547, 11);
        fly(419);
        check_pos("g2 paddle row", 128, 430);
        fly(1);
        check_pos("g2 paddle bounce", 127, 429);

        // Reset in the middle of PLAY
        rst = 1'b1;
        cyc();
        check("mid rst state", 32'(state), 32'(IDLE));
        check_pos("mid rst", 320, 400);
        rst = 1'b0;
        cyc();
        check("g3 state", 32'(state), 32'(PLAY));

        // Game 3: table-driven block hits through the scoreboard
        for (int i = 0; i < 18; i++) begin
            animate   = tbl[i].anim;
            ani_stb   = tbl[i].stb;
            hit_block = tbl[i].hit;
            sbq.push_back(tbl[i]);
            cyc();
            e = sbq.pop_front();
            check($sformatf("tbl[%0d] x", i), 32'(x), 32'(e.ex));
            check($sformatf("tbl[%0d] y", i), 32'(y), 32'(e.ey));
            check($sformatf("tbl[%0d] col", i), 32'(col_detected), 32'(e.ecol));
        end
        ani_stb   = 1'b0;
        animate   = 1'b1;
        hit_block = HIT_NONE;

        // Game 4: eight hits, then the divider with and without speed-up
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            hit_block = HIT_V;
            cyc();
            hit_block = HIT_NONE;
            if (col_detected) n_ack++;
            for (int j = 0; j < 3; j++) begin
                cyc();
                if (col_detected) n_ack++;
            end
        end
        check("g4 ack count", 32'(n_ack), 8);
        strobe();
`ifdef BALL_SPEEDUP_EN
        check_pos("g4 fast 1", 321, 399);
        strobe();
        check_pos("g4 fast 2", 322, 398);
`else
        check_pos("g4 slow 1", 320, 400);
        strobe();
        check_pos("g4 slow 2", 321, 399);
`endif
        rst = 1'b1;
        cyc();
        check_pos("g4 rst", 320, 400);
        rst = 1'b0;
        cyc();
        strobe();
        check_pos("g4 restored 1", 320, 400);
        strobe();
        check_pos("g4 restored 2", 321, 399);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
